// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

   typedef enum logic [0:0] {ARB_NORMAL, ARB_STARVED} wb_arb_state_e;

   localparam logic [3:0] REG_X0 = 4'd0;

endpackage

// File: rtl/wb_starve_counter.sv
// Saturating count of consecutive cycles the MCU has lost arbitration.
module wb_starve_counter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_limit_m1
);

   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] Limit   = CntW'(STARVE_LIMIT);
   localparam logic [CntW-1:0] LimitM1 = CntW'(STARVE_LIMIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != Limit)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_m1 = (cnt_q == LimitM1);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single regfile write port between the WB stage and one multi-cycle unit.
// Define WB_PORT_ARB_PERF_EN to add the conflict_cnt performance counter.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned REG_AW       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              regfile_we_WB,
   input  logic              invalid_WB,
   input  logic [REG_AW-1:0] rd_WB,
   input  logic [DATA_W-1:0] rd_data_WB,
   input  logic              mcu_req,
   input  logic [REG_AW-1:0] mcu_rd,
   input  logic [DATA_W-1:0] mcu_data,
   output logic              mcu_ack,
   output logic              stall_WB,
   output logic              regfile_we,
   output logic [REG_AW-1:0] regfile_waddr,
   output logic [DATA_W-1:0] regfile_wdata
`ifdef WB_PORT_ARB_PERF_EN
   ,
   output logic [31:0]       conflict_cnt
`endif
);

   localparam logic [REG_AW-1:0] RegZero = REG_AW'(REG_X0);

   wb_arb_state_e state_q, state_d;

   logic p, m;
   logic grant_mcu, grant_pipe;
   logic cnt_inc, cnt_clr, at_limit_m1;

   always_comb begin
      p          = regfile_we_WB & ~invalid_WB & (rd_WB != RegZero);
      m          = mcu_req;
      grant_mcu  = 1'b0;
      state_d    = state_q;
      unique case (state_q)
         ARB_NORMAL: begin
            grant_mcu = m & ~p;
            if (m & ~grant_mcu & at_limit_m1) begin
               state_d = ARB_STARVED;
            end
         end
         ARB_STARVED: begin
            grant_mcu = m;
            // Leaves on the forced grant, or on an illegally dropped request.
            state_d   = ARB_NORMAL;
         end
         default: state_d = ARB_NORMAL;
      endcase
      grant_pipe = p & ~grant_mcu;
      cnt_inc    = m & ~grant_mcu;
      cnt_clr    = grant_mcu | ((state_q == ARB_STARVED) & ~m);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_NORMAL;
      end else begin
         state_q <= state_d;
      end
   end

   wb_starve_counter #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc        (cnt_inc),
      .clr        (cnt_clr),
      .at_limit_m1(at_limit_m1)
   );

   // Gated by reset so nothing is granted while the write register is held clear.
   assign mcu_ack  = grant_mcu & rst_n;
   assign stall_WB = p & grant_mcu & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regfile_we    <= 1'b0;
         regfile_waddr <= '0;
         regfile_wdata <= '0;
      end else begin
         regfile_we <= grant_pipe | (grant_mcu & (mcu_rd != RegZero));
         if (grant_pipe) begin
            regfile_waddr <= rd_WB;
            regfile_wdata <= rd_data_WB;
         end else if (grant_mcu) begin
            regfile_waddr <= mcu_rd;
            regfile_wdata <= mcu_data;
         end
      end
   end

`ifdef WB_PORT_ARB_PERF_EN
   logic conflict;
   assign conflict = (p & grant_mcu) | (m & ~grant_mcu);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt <= '0;
      end else if (conflict && (conflict_cnt != '1)) begin
         conflict_cnt <= conflict_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized self-checking bench for wb_port_arbiter against a cycle-level reference model.
module tb_wb_port_arbiter;

   localparam int unsigned LIMIT = 4;

   logic        clk;
   logic        rst_n;
   logic        regfile_we_WB;
   logic        invalid_WB;
   logic [3:0]  rd_WB;
   logic [31:0] rd_data_WB;
   logic        mcu_req;
   logic [3:0]  mcu_rd;
   logic [31:0] mcu_data;
   logic        mcu_ack;
   logic        stall_WB;
   logic        regfile_we;
   logic [3:0]  regfile_waddr;
   logic [31:0] regfile_wdata;
`ifdef WB_PORT_ARB_PERF_EN
   logic [31:0] conflict_cnt;
`endif

   wb_port_arbiter #(
      .STARVE_LIMIT(LIMIT),
      .DATA_W      (32),
      .REG_AW      (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .regfile_we_WB(regfile_we_WB),
      .invalid_WB   (invalid_WB),
      .rd_WB        (rd_WB),
      .rd_data_WB   (rd_data_WB),
      .mcu_req      (mcu_req),
      .mcu_rd       (mcu_rd),
      .mcu_data     (mcu_data),
      .mcu_ack      (mcu_ack),
      .stall_WB     (stall_WB),
      .regfile_we   (regfile_we),
      .regfile_waddr(regfile_waddr),
      .regfile_wdata(regfile_wdata)
`ifdef WB_PORT_ARB_PERF_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: how many cycles in a row the MCU has lost.
   int          losses;
   logic        exp_we;
   logic [3:0]  exp_waddr;
   logic [31:0] exp_wdata;
   longint      exp_conflicts;
   logic        last_grant_mcu;
   logic        last_stall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      losses        = 0;
      exp_we        = 1'b0;
      exp_waddr     = '0;
      exp_wdata     = '0;
      exp_conflicts = 0;
   endtask

   // Called at posedge+1: drives one cycle, checks grants at the falling edge and the
   // registered write port just after the next rising edge.
   task automatic step(input logic pwe, input logic inv, input logic [3:0] rd,
                       input logic [31:0] d, input logic mreq, input logic [3:0] mrd,
                       input logic [31:0] md);
      logic want_p, gm, gp;
      regfile_we_WB = pwe;
      invalid_WB    = inv;
      rd_WB         = rd;
      rd_data_WB    = d;
      mcu_req       = mreq;
      mcu_rd        = mrd;
      mcu_data      = md;
      #4;
      want_p = pwe && !inv && (rd != 4'd0);
      // The MCU wins when the pipeline is idle or it has already lost LIMIT times running.
      gm     = mreq && (!want_p || losses >= int'(LIMIT));
      gp     = want_p && !gm;
      check("mcu_ack", {31'd0, mcu_ack}, {31'd0, gm});
      check("stall_WB", {31'd0, stall_WB}, {31'd0, want_p && gm});
      last_grant_mcu = gm;
      last_stall     = want_p && gm;
      if ((want_p && gm) || (mreq && !gm)) exp_conflicts++;
      if (gm) losses = 0;
      else if (mreq && losses < int'(LIMIT)) losses++;
      exp_we = gp || (gm && mrd != 4'd0);
      if (gp) begin
         exp_waddr = rd;
         exp_wdata = d;
      end else if (gm) begin
         exp_waddr = mrd;
         exp_wdata = md;
      end
      @(posedge clk);
      #1;
      check("regfile_we", {31'd0, regfile_we}, {31'd0, exp_we});
      check("regfile_waddr", {28'd0, regfile_waddr}, {28'd0, exp_waddr});
      check("regfile_wdata", regfile_wdata, exp_wdata);
`ifdef WB_PORT_ARB_PERF_EN
      check("conflict_cnt", conflict_cnt,
            (exp_conflicts > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : exp_conflicts[31:0]);
`endif
   endtask

   logic        r_pwe, r_inv, r_mreq;
   logic [3:0]  r_rd, r_mrd;
   logic [31:0] r_d, r_md;

   initial begin
      model_reset();
      rst_n = 1'b0;
      regfile_we_WB = 0; invalid_WB = 0; rd_WB = 0; rd_data_WB = 0;
      mcu_req = 0; mcu_rd = 0; mcu_data = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_we", {31'd0, regfile_we}, 32'd0);
      check("rst_waddr", {28'd0, regfile_waddr}, 32'd0);
      check("rst_wdata", regfile_wdata, 32'd0);
      check("rst_ack", {31'd0, mcu_ack}, 32'd0);
      rst_n = 1'b1;

      // Pipeline only.
      step(1, 0, 4'd5, 32'hDEAD_BEEF, 0, 4'd0, 32'd0);
      check("pipe_we", {31'd0, regfile_we}, 32'd1);
      check("pipe_waddr", {28'd0, regfile_waddr}, 32'd5);
      check("pipe_wdata", regfile_wdata, 32'hDEAD_BEEF);
      check("pipe_stall", {31'd0, last_stall}, 32'd0);

      // MCU only.
      step(0, 0, 4'd0, 32'd0, 1, 4'd3, 32'h12);
      check("mcu_only_wdata", regfile_wdata, 32'h12);

      // Contention: pipeline wins four times, MCU forced through on the fifth.
      model_reset();
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 4'd9, 32'hA000_0000 + 32'(i), (i <= 4), 4'd11, 32'h5555_0000);
         if (i < 4) check("cont_pipe_wins", {31'd0, last_grant_mcu}, 32'd0);
         if (i == 4) begin
            check("cont_forced_ack", {31'd0, last_grant_mcu}, 32'd1);
            check("cont_forced_stall", {31'd0, last_stall}, 32'd1);
            check("cont_mcu_write", {28'd0, regfile_waddr}, 32'd11);
`ifdef WB_PORT_ARB_PERF_EN
            check("cont_conflicts", conflict_cnt, 32'd5);
`endif
         end
         if (i == 5) check("cont_pipe_again", {28'd0, regfile_waddr}, 32'd9);
      end

      // Filters: invalid pipeline never writes, x0 MCU result is acked without a write.
      step(1, 1, 4'd7, 32'h7777, 0, 4'd0, 32'd0);
      check("inv_no_write", {31'd0, regfile_we}, 32'd0);
      step(1, 0, 4'd0, 32'h1, 1, 4'd0, 32'h99);
      check("x0_mcu_ack", {31'd0, last_grant_mcu}, 32'd1);
      check("x0_no_write", {31'd0, regfile_we}, 32'd0);

      // Asynchronous reset while starved.
      for (int i = 0; i < 4; i++) step(1, 0, 4'd4, 32'h44, 1, 4'd6, 32'h66);
      regfile_we_WB = 1; invalid_WB = 0; rd_WB = 4'd4; mcu_req = 1; mcu_rd = 4'd6;
      #1;
      check("pre_rst_ack", {31'd0, mcu_ack}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_ack", {31'd0, mcu_ack}, 32'd0);
      check("midrst_stall", {31'd0, stall_WB}, 32'd0);
      check("midrst_we", {31'd0, regfile_we}, 32'd0);
      check("midrst_waddr", {28'd0, regfile_waddr}, 32'd0);
      check("midrst_wdata", regfile_wdata, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      step(1, 0, 4'd4, 32'h44, 1, 4'd6, 32'h66);
      check("post_rst_normal", {31'd0, last_grant_mcu}, 32'd0);

      // Randomized traffic obeying the stall and request-hold protocols.
      r_mreq = 1'b1; r_mrd = 4'd6; r_md = 32'h66;
      r_pwe = 1'b1; r_inv = 1'b0; r_rd = 4'd4; r_d = 32'h44;
      last_stall = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (!last_stall) begin
            r_pwe = ($urandom_range(3) != 0);
            r_inv = ($urandom_range(3) == 0);
            r_rd  = 4'($urandom_range(15));
            r_d   = $urandom;
         end
         if (!r_mreq || last_grant_mcu) begin
            r_mreq = ($urandom_range(2) == 0);
            r_mrd  = 4'($urandom_range(15));
            r_md   = $urandom;
         end
         step(r_pwe, r_inv, r_rd, r_d, r_mreq, r_mrd, r_md);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
